// File: rtl/hazard_scoreboard_if.sv
// Issue/writeback bundle between the decode stage and the hazard scoreboard.
// The master drives the ID-stage and writeback fields. The slave returns the stall and status signals.
interface hazard_scoreboard_if #(
    parameter int N_REGISTER = 8,
    parameter int N_NUMBERS  = $clog2(N_REGISTER)
);
    logic                  issue_valid;
    logic                  writes_rd;
    logic [N_NUMBERS-1:0]  Rd_NUM_ID;
    logic                  rn_used;
    logic [N_NUMBERS-1:0]  Rn_NUM_ID;
    logic                  rm_used;
    logic [N_NUMBERS-1:0]  Rm_NUM_ID;
    logic                  wb_valid;
    logic [N_NUMBERS-1:0]  wb_NUM;
    logic                  flush;
    logic                  stall;
    logic [N_REGISTER-1:0] pending;
    logic [7:0]            stall_run;
    logic                  wb_err;

    modport master (
        output issue_valid, writes_rd, Rd_NUM_ID, rn_used, Rn_NUM_ID,
               rm_used, Rm_NUM_ID, wb_valid, wb_NUM, flush,
        input  stall, pending, stall_run, wb_err
    );

    modport slave (
        input  issue_valid, writes_rd, Rd_NUM_ID, rn_used, Rn_NUM_ID,
               rm_used, Rm_NUM_ID, wb_valid, wb_NUM, flush,
        output stall, pending, stall_run, wb_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard: per-register 2-bit outstanding-write counters drive a same-cycle ID stall.
// Optional macro HAZARD_BYPASS_EN lets a source whose last outstanding write retires this cycle skip the stall.
module hazard_scoreboard #(
    parameter int N_REGISTER = 8,
    parameter int N_NUMBERS  = $clog2(N_REGISTER)
) (
    input  logic             clk,
    input  logic             reset,
    hazard_scoreboard_if.slave sb
);

    logic [1:0]            cnt_q [N_REGISTER];
    logic [1:0]            cnt_d [N_REGISTER];
    logic                  wb_err_q, wb_err_d;
    logic [7:0]            stall_run_q, stall_run_d;

    logic [N_REGISTER-1:0] pending;
    logic                  hazard_rn;
    logic                  hazard_rm;
    logic                  hazard_waw;
    logic                  stall;
    logic                  accept;
    logic                  wb_underflow;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REGISTER; i++) begin
            pending[i] = (cnt_q[i] != 2'd0);
        end
    end

    always_comb begin
        hazard_rn = sb.rn_used & pending[sb.Rn_NUM_ID];
        hazard_rm = sb.rm_used & pending[sb.Rm_NUM_ID];
`ifdef HAZARD_BYPASS_EN
        // The last outstanding write lands this cycle, so the operand comes from writeback.
        if (sb.wb_valid && (sb.wb_NUM == sb.Rn_NUM_ID) && (cnt_q[sb.Rn_NUM_ID] == 2'd1))
            hazard_rn = 1'b0;
        if (sb.wb_valid && (sb.wb_NUM == sb.Rm_NUM_ID) && (cnt_q[sb.Rm_NUM_ID] == 2'd1))
            hazard_rm = 1'b0;
`endif
        // Rd itself is never a read hazard. Only counter saturation blocks a write.
        hazard_waw = sb.writes_rd & (cnt_q[sb.Rd_NUM_ID] == 2'd3);
    end

    always_comb begin
        stall        = ~reset & sb.issue_valid & ~sb.flush & (hazard_rn | hazard_rm | hazard_waw);
        accept       = ~reset & sb.issue_valid & ~sb.flush & ~stall;
        wb_underflow = sb.wb_valid & ~pending[sb.wb_NUM];
    end

    always_comb begin
        for (int i = 0; i < N_REGISTER; i++) begin
            logic inc;
            logic dec;
            inc = accept & sb.writes_rd & (sb.Rd_NUM_ID == N_NUMBERS'(i));
            dec = sb.wb_valid & (sb.wb_NUM == N_NUMBERS'(i)) & pending[i];
            cnt_d[i] = cnt_q[i];
            // A simultaneous issue and retire on one register leaves the count unchanged.
            if (inc && !dec)
                cnt_d[i] = cnt_q[i] + 2'd1;
            else if (dec && !inc)
                cnt_d[i] = cnt_q[i] - 2'd1;
        end
    end

    always_comb begin
        wb_err_d    = wb_err_q | wb_underflow;
        stall_run_d = stall ? sat_inc8(stall_run_q) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGISTER; i++) begin
                cnt_q[i] <= 2'd0;
            end
            wb_err_q    <= 1'b0;
            stall_run_q <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            wb_err_q    <= wb_err_d;
            stall_run_q <= stall_run_d;
        end
    end

    assign sb.stall     = stall;
    assign sb.pending   = pending;
    assign sb.stall_run = stall_run_q;
    assign sb.wb_err    = wb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Vector-table bench for hazard_scoreboard: stall is checked in the driving cycle, and state is checked after the edge.
module tb_hazard_scoreboard;

`ifdef HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit         rst;
        bit         iv;
        bit         wr;
        logic [2:0] rd;
        bit         rnu;
        logic [2:0] rn;
        bit         rmu;
        logic [2:0] rm;
        bit         wbv;
        logic [2:0] wbn;
        bit         fl;
        bit         exp_stall;
        logic [7:0] exp_pend;
        int         exp_run;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t sbq[$];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.N_REGISTER(8), .N_NUMBERS(3)) sb ();

    hazard_scoreboard #(.N_REGISTER(8), .N_NUMBERS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb.slave)
    );

    function automatic vec_t mk(bit rst, bit iv, bit wr, int rd, bit rnu, int rn, bit rmu, int rm,
                                bit wbv, int wbn, bit fl, bit es, logic [7:0] ep, int er, bit ee);
        vec_t v;
        v.rst = rst; v.iv = iv; v.wr = wr; v.rd = 3'(rd);
        v.rnu = rnu; v.rn = 3'(rn); v.rmu = rmu; v.rm = 3'(rm);
        v.wbv = wbv; v.wbn = 3'(wbn); v.fl = fl;
        v.exp_stall = es; v.exp_pend = ep; v.exp_run = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        reset          = v.rst;
        sb.issue_valid = v.iv;
        sb.writes_rd   = v.wr;
        sb.Rd_NUM_ID   = v.rd;
        sb.rn_used     = v.rnu;
        sb.Rn_NUM_ID   = v.rn;
        sb.rm_used     = v.rmu;
        sb.Rm_NUM_ID   = v.rm;
        sb.wb_valid    = v.wbv;
        sb.wb_NUM      = v.wbn;
        sb.flush       = v.fl;
        #1;
        checks++;
        if (sb.stall !== v.exp_stall) begin
            failures++;
            $display("FAIL %s stall got=%0b exp=%0b", tag, sb.stall, v.exp_stall);
        end
        sbq.push_back(v);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if (sb.pending !== e.exp_pend) begin
            failures++;
            $display("FAIL %s pending got=%02h exp=%02h", tag, sb.pending, e.exp_pend);
        end
        checks++;
        if (sb.stall_run !== 8'(e.exp_run)) begin
            failures++;
            $display("FAIL %s stall_run got=%0d exp=%0d", tag, sb.stall_run, e.exp_run);
        end
        checks++;
        if (sb.wb_err !== e.exp_err) begin
            failures++;
            $display("FAIL %s wb_err got=%0b exp=%0b", tag, sb.wb_err, e.exp_err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sb.issue_valid = 0; sb.writes_rd = 0; sb.Rd_NUM_ID = 0; sb.rn_used = 0; sb.Rn_NUM_ID = 0;
        sb.rm_used = 0; sb.Rm_NUM_ID = 0; sb.wb_valid = 0; sb.wb_NUM = 0; sb.flush = 0;

        //               rst iv wr rd rnu rn rmu rm wbv wbn fl  stall     pend   run           err
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       8'h00, 0,            0)); // 0 reset
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,       8'h08, 0,            0)); // 1 write r3
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1,       8'h08, 1,            0)); // 2 RAW r3
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1,       8'h08, 2,            0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1,       8'h08, 3,            0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 1, 3, 0, !BYP,    8'h00, BYP ? 0 : 4,  0)); // 5 wb r3
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,       8'h00, 0,            0));
        vecs.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,       8'h20, 0,            0)); // 7 write r5
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 1, 5, 0, !BYP,    8'h00, BYP ? 0 : 1,  0)); // 8 bypass case
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,       8'h00, 0,            0));
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,       8'h04, 0,            0)); // 10 r2 x3
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,       8'h04, 0,            0));
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,       8'h04, 0,            0));
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1,       8'h04, 1,            0)); // 13 WAW sat
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 2, 0, 1,       8'h04, 2,            0)); // 14 wb r2
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,       8'h04, 0,            0)); // 15 accepted
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1,       8'h04, 1,            0)); // 16 back at 3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,       8'h04, 0,            0)); // 17 drain
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,       8'h04, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,       8'h00, 0,            0));
        vecs.push_back(mk(0, 1, 1, 4, 1, 4, 0, 0, 0, 0, 0, 0,       8'h10, 0,            0)); // 20 own Rd
        vecs.push_back(mk(0, 1, 1, 4, 1, 4, 0, 0, 0, 0, 0, 1,       8'h10, 1,            0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0,       8'h00, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,       8'h00, 0,            1)); // 23 underflow
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       8'h00, 0,            1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       8'h02, 0,            1)); // 25 write r1
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0,       8'h00, 0,            1)); // 26 flush+wb
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,       8'h00, 0,            1));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,       8'h80, 0,            1)); // 28 write r7
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1,       8'h80, 1,            1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1,       8'h80, 2,            1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,       8'h00, 0,            0)); // 31 reset mid-stall
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,       8'h00, 0,            0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       8'h01, 0,            0)); // 33 r0 is normal
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1,       8'h01, 1,            0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,       8'h00, 0,            0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       8'h00, 0,            0)); // 36 reset wins

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Saturation: hold a RAW stall on r7 for 300 cycles.
        apply(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80, 0, 0), "sat_setup");
        for (int k = 1; k <= 300; k++) begin
            apply(mk(0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 8'h80, (k > 255) ? 255 : k, 0),
                  $sformatf("sat%0d", k));
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 8'h00, 0, 0), "sat_release");

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
